ahb_rom_if: RTL and testbench
=============================

AHB_ROM_IF -- requirements
Module: ahb_rom_if

Interface
REQ-001 Parameter ROM_AW, default 13: ROM word-address width (8192 x 32-bit words, 32 KB).
REQ-002 Parameter ERRCNT_W, default 8: width of the saturating error counter.
REQ-003 HCLK  in  1  single clock; all state updates on rising edge.
REQ-004 HRESET  in  1  reset, synchronous, active-high.
REQ-005 HSEL  in  1  slave select from the external address decoder.
REQ-006 HADDR  in  32  AHB-Lite address; bits [ROM_AW+1:2] are used, bits above are ignored.
REQ-007 HTRANS  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 HWRITE  in  1  1 = write transfer.
REQ-009 HSIZE  in  3  transfer size (000 byte, 001 halfword, 010 word, others illegal).
REQ-010 HREADY  in  1  bus-wide ready (address-phase qualifier).
REQ-011 HREADYOUT  out  1  slave ready for the current data phase.
REQ-012 HRESP  out  1  0 = OKAY, 1 = ERROR.
REQ-013 HRDATA  out  32  read data.
REQ-014 rom_addr  out  ROM_AW  word address to the synchronous ROM.
REQ-015 rom_cs  out  1  ROM read enable; the ROM registers its data on the same edge.
REQ-016 rom_rdata  in  32  ROM registered output, valid one cycle after rom_cs.
REQ-017 err_count  out  ERRCNT_W  count of ERROR responses issued, saturating.

Function
REQ-018 Address phase is accepted when HSEL & HREADY & HTRANS[1] = 1; this is "valid".
REQ-019 A valid transfer is "bad" if any of the following holds: HWRITE=1; HSIZE>010; HSIZE=001 and HADDR[0]=1; or HSIZE=010 and HADDR[1:0]!=00.
REQ-020 A valid transfer that is not bad is a "good read".
REQ-021 rom_addr = HADDR[ROM_AW+1:2] combinationally at all times.
REQ-022 rom_cs = good-read condition combinationally, forced to 0 while HRESET=1.
REQ-023 FSM states: IDLE, READ, ERR1, ERR2.
REQ-024 IDLE/READ/ERR2 transitions: good read -> READ; bad transfer -> ERR1; otherwise -> IDLE.
REQ-025 ERR1 transitions: unconditionally -> ERR2; no address phase is sampled in ERR1, because HREADY is low.
REQ-026 IDLE outputs: HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-027 READ outputs: HREADYOUT=1, HRESP=0, HRDATA=rom_rdata; zero wait states; read latency is one cycle from address phase to data.
REQ-028 ERR1 outputs: HREADYOUT=0, HRESP=1, HRDATA=0.
REQ-029 ERR2 outputs: HREADYOUT=1, HRESP=1, HRDATA=0.
REQ-030 Byte and halfword reads return the full 32-bit ROM word; lane selection is the master's responsibility.
REQ-031 IDLE and BUSY transfers, and any cycle with HSEL=0 or HREADY=0 outside ERR1, produce IDLE (OKAY, zero wait).
REQ-032 Back-to-back good reads (NONSEQ then SEQ) issue rom_cs on consecutive cycles and sustain one word per cycle.
REQ-033 A valid transfer sampled in ERR2 is accepted normally (pipelined after the error).
REQ-034 err_count increments by 1 on each entry to ERR1 and holds at all-ones (255 by default) once saturated.
REQ-035 HRDATA is never driven from rom_rdata outside READ, so stale ROM output cannot leak.

Reset
REQ-036 While HRESET=1: FSM=IDLE, err_count=0, HREADYOUT=1, HRESP=0, HRDATA=0, rom_cs=0.
REQ-037 Reset asserted during READ or ERR1/ERR2 aborts the transfer; the next cycle after release is IDLE.
REQ-038 The ROM output register is not reset; REQ-035 covers the resulting undefined contents.

Verification
REQ-039 Word read at HADDR=0x0000_0010 with ROM word 4 = 0xDEADBEEF -> rom_cs=1 and rom_addr=4 in the address cycle; next cycle HRDATA=0xDEADBEEF, HREADYOUT=1, HRESP=0.
REQ-040 Four SEQ word reads at 0x0, 0x4, 0x8, 0xC -> HRDATA returns words 0..3 on four consecutive cycles with no wait states.
REQ-041 Write to 0x20 -> one cycle HREADYOUT=0/HRESP=1, then one cycle HREADYOUT=1/HRESP=1; rom_cs stays 0; err_count goes 0 -> 1.
REQ-042 Word read at 0x2 and halfword read at 0x1 -> each gets a two-cycle ERROR; a good read issued in the ERR2 cycle completes OKAY the following cycle.
REQ-043 300 bad transfers -> err_count saturates at 255.
REQ-044 HRESET asserted in the ERR1 cycle -> next cycle HREADYOUT=1, HRESP=0, err_count=0.

Source files
------------

// File: rtl/ahb_rom_if.sv
// ============================================================================
//  ahb_rom_if : AHB-Lite read-only slave in front of a synchronous 32-bit ROM
//  Rev 1.0
// ============================================================================
`default_nettype none

module ahb_rom_if #(
  parameter int ROM_AW   = 13,
  parameter int ERRCNT_W = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [31:0]         HRDATA,
  output logic [ROM_AW-1:0]   rom_addr,
  output logic                rom_cs,
  input  logic [31:0]         rom_rdata,
  output logic [ERRCNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  localparam logic [ERRCNT_W-1:0] C_ERR_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ERRCNT_W-1:0]   err_count_q, err_count_d;
  logic                  w_valid;
  logic                  w_bad;
  logic                  w_good_rd;
  logic                  unused_bits;

  assign unused_bits = ^{HADDR[31:ROM_AW+2], HTRANS[0]};

  // Writes, oversize and misaligned accesses are all rejected with ERROR.
  always_comb begin
    w_valid   = HSEL & HREADY & HTRANS[1];
    w_bad     = HWRITE
              | (HSIZE > 3'b010)
              | ((HSIZE == 3'b001) & HADDR[0])
              | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));
    w_good_rd = w_valid & ~w_bad;
  end

  assign rom_addr  = HADDR[ROM_AW+1:2];
  assign rom_cs    = w_good_rd & ~HRESET;
  assign err_count = err_count_q;

  always_comb begin
    state_d     = state_q;
    err_count_d = err_count_q;
    case (state_q)
      S_ERR1:  state_d = S_ERR2;
      default: begin
        if (w_good_rd)                state_d = S_READ;
        else if (w_valid && w_bad)    state_d = S_ERR1;
        else                          state_d = S_IDLE;
      end
    endcase
    if (state_d == S_ERR1 && err_count_q != {ERRCNT_W{1'b1}}) begin
      err_count_d = err_count_q + C_ERR_ONE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      err_count_q <= err_count_d;
    end
  end

  // Read data is gated by state so stale ROM output never reaches the bus.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    if (!HRESET) begin
      case (state_q)
        S_READ:  HRDATA = rom_rdata;
        S_ERR1:  begin
          HREADYOUT = 1'b0;
          HRESP     = 1'b1;
        end
        S_ERR2:  HRESP = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_rom_if.sv
// ============================================================================
//  tb_ahb_rom_if : directed self-checking bench for ahb_rom_if
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_ahb_rom_if;

  localparam int ROM_AW   = 13;
  localparam int ERRCNT_W = 8;

  logic                HCLK = 1'b0;
  logic                HRESET;
  logic                HSEL;
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic                HWRITE;
  logic [2:0]          HSIZE;
  logic                HREADY;
  logic                HREADYOUT;
  logic                HRESP;
  logic [31:0]         HRDATA;
  logic [ROM_AW-1:0]   rom_addr;
  logic                rom_cs;
  logic [31:0]         rom_rdata;
  logic [ERRCNT_W-1:0] err_count;

  logic [31:0] rom_mem [0:(1<<ROM_AW)-1];

  int n_vec = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (rom_cs) rom_rdata <= rom_mem[rom_addr];
  end

  ahb_rom_if #(.ROM_AW(ROM_AW), .ERRCNT_W(ERRCNT_W)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_rdata (rom_rdata),
    .err_count (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply an address phase and let combinational outputs settle.
  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic rdy);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
    HREADY = rdy;
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, rdy);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_phase(input string tag, input logic rdy, input logic resp,
                           input logic [31:0] data);
    chk({tag, ".hreadyout"}, {31'h0, HREADYOUT}, {31'h0, rdy});
    chk({tag, ".hresp"},     {31'h0, HRESP},     {31'h0, resp});
    chk({tag, ".hrdata"},    HRDATA,             data);
  endtask

  initial begin
    for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 32'hC0DE_0000 | i;
    rom_mem[0] = 32'h1111_1111;
    rom_mem[1] = 32'h2222_2222;
    rom_mem[2] = 32'h3333_3333;
    rom_mem[3] = 32'h4444_4444;
    rom_mem[4] = 32'hDEAD_BEEF;
    rom_rdata  = 32'h5A5A_5A5A;

    // Reset: a good read presented during reset must not enable the ROM.
    HRESET = 1'b1;
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h10, 1'b1);
    chk("rst.rom_cs", {31'h0, rom_cs}, 32'h0);
    step();
    step();
    chk_phase("rst", 1'b1, 1'b0, 32'h0);
    chk("rst.err_count", {24'h0, err_count}, 32'h0);

    // Single word read of word 4.
    HRESET = 1'b0;
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0010, 1'b1);
    chk("rd4.rom_cs", {31'h0, rom_cs}, 32'h1);
    chk("rd4.rom_addr", {19'h0, rom_addr}, 32'h4);
    step();
    chk_phase("rd4", 1'b1, 1'b0, 32'hDEAD_BEEF);
    idle(1'b1);
    chk("idle.rom_cs", {31'h0, rom_cs}, 32'h0);
    step();
    chk_phase("idle_after_rd", 1'b1, 1'b0, 32'h0);

    // Burst of four words, one per cycle.
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h0, 1'b1);
    step();
    chk_phase("burst0", 1'b1, 1'b0, 32'h1111_1111);
    drive(1'b1, 2'b11, 1'b0, 3'b010, 32'h4, 1'b1);
    chk("burst1.rom_cs", {31'h0, rom_cs}, 32'h1);
    step();
    chk_phase("burst1", 1'b1, 1'b0, 32'h2222_2222);
    drive(1'b1, 2'b11, 1'b0, 3'b010, 32'h8, 1'b1);
    step();
    chk_phase("burst2", 1'b1, 1'b0, 32'h3333_3333);
    drive(1'b1, 2'b11, 1'b0, 3'b010, 32'hC, 1'b1);
    step();
    chk_phase("burst3", 1'b1, 1'b0, 32'h4444_4444);

    // Upper address bits ignored; byte read returns the whole word.
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'hFFFF_0008, 1'b1);
    chk("hiaddr.rom_addr", {19'h0, rom_addr}, 32'h2);
    step();
    chk_phase("hiaddr", 1'b1, 1'b0, 32'h3333_3333);
    drive(1'b1, 2'b10, 1'b0, 3'b000, 32'h3, 1'b1);
    step();
    chk_phase("byte3", 1'b1, 1'b0, 32'h1111_1111);

    // BUSY, deselected and not-ready cycles give IDLE.
    drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h4, 1'b1);
    chk("busy.rom_cs", {31'h0, rom_cs}, 32'h0);
    step();
    chk_phase("busy", 1'b1, 1'b0, 32'h0);
    drive(1'b0, 2'b10, 1'b0, 3'b010, 32'h4, 1'b1);
    chk("nosel.rom_cs", {31'h0, rom_cs}, 32'h0);
    step();
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h4, 1'b0);
    chk("nordy.rom_cs", {31'h0, rom_cs}, 32'h0);
    step();
    chk_phase("nordy", 1'b1, 1'b0, 32'h0);

    // Write gives a two-cycle ERROR and bumps the counter.
    drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h20, 1'b1);
    chk("wr.rom_cs", {31'h0, rom_cs}, 32'h0);
    step();
    chk_phase("wr.err1", 1'b0, 1'b1, 32'h0);
    chk("wr.err_count", {24'h0, err_count}, 32'h1);
    idle(1'b0);
    step();
    chk_phase("wr.err2", 1'b1, 1'b1, 32'h0);

    // Misaligned word, then halfword pipelined in ERR2, then good read in ERR2.
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h2, 1'b1);
    chk("misw.rom_cs", {31'h0, rom_cs}, 32'h0);
    step();
    chk_phase("misw.err1", 1'b0, 1'b1, 32'h0);
    idle(1'b0);
    step();
    chk_phase("misw.err2", 1'b1, 1'b1, 32'h0);
    drive(1'b1, 2'b10, 1'b0, 3'b001, 32'h1, 1'b1);
    step();
    chk_phase("mish.err1", 1'b0, 1'b1, 32'h0);
    idle(1'b0);
    step();
    chk_phase("mish.err2", 1'b1, 1'b1, 32'h0);
    drive(1'b1, 2'b10, 1'b0, 3'b010, 32'h4, 1'b1);
    chk("err2rd.rom_cs", {31'h0, rom_cs}, 32'h1);
    step();
    chk_phase("err2rd", 1'b1, 1'b0, 32'h2222_2222);
    chk("mis.err_count", {24'h0, err_count}, 32'h3);

    // Illegal size is an error even when aligned.
    drive(1'b1, 2'b10, 1'b0, 3'b011, 32'h0, 1'b1);
    step();
    chk_phase("size3.err1", 1'b0, 1'b1, 32'h0);
    chk("size3.err_count", {24'h0, err_count}, 32'h4);
    idle(1'b0);
    step();

    // Reset during ERR1 aborts the error and clears the counter.
    drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h0, 1'b1);
    step();
    chk_phase("rsterr.err1", 1'b0, 1'b1, 32'h0);
    HRESET = 1'b1;
    idle(1'b0);
    step();
    chk_phase("rsterr.after", 1'b1, 1'b0, 32'h0);
    chk("rsterr.err_count", {24'h0, err_count}, 32'h0);
    HRESET = 1'b0;
    idle(1'b1);
    step();
    chk_phase("rsterr.release", 1'b1, 1'b0, 32'h0);

    // 300 bad transfers saturate the counter.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'b10, 1'b1, 3'b010, 32'h20, 1'b1);
      step();
      if (i == 253) chk("sat.254", {24'h0, err_count}, 32'd254);
      if (i == 254) chk("sat.255", {24'h0, err_count}, 32'd255);
      idle(1'b0);
      step();
    end
    chk("sat.300", {24'h0, err_count}, 32'd255);
    chk_phase("sat.err2", 1'b1, 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
